// File: rtl/phi_pkg.sv
// rtl/phi_pkg.sv - shared defaults and strobe index constants for phi_tracker
package phi_pkg;

   // Default parameter values for phi_tracker and phi_edge_sync
   localparam int PHI_CNT_W      = 8;
   localparam int PHI_GUARD_BITS = 4;
   localparam int PHI_SYNC_LEN   = 4;
   localparam int PHI_LOCK_BITS  = 4;
   localparam int PHI_TOL_BITS   = 2;

   // Bit positions inside the strobe delay lines (oldest tap is P1)
   localparam int STB_M2 = 0;
   localparam int STB_M1 = 1;
   localparam int STB_P0 = 2;
   localparam int STB_P1 = 3;

endpackage

// File: rtl/phi_edge_sync.sv
// rtl/phi_edge_sync.sv - PHI2 synchroniser and falling-edge qualifier
// Ports: clk, reset_n (async active-low); i_phi2 asynchronous host PHI2;
// o_sync one-cycle pulse on a qualified falling edge; o_level synced level.
module phi_edge_sync
   import phi_pkg::*;
#(
   parameter int SYNC_LEN = PHI_SYNC_LEN
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_phi2,
   output logic o_sync,
   output logic o_level
);

   logic [SYNC_LEN-1:0] r_shift;
   logic                r_sync;

   // A falling edge only qualifies after SYNC_LEN-1 consecutive high samples,
   // so short high blips during the low phase never produce a sync.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift <= '0;
         r_sync  <= 1'b0;
      end else begin
         r_shift <= {r_shift[SYNC_LEN-2:0], i_phi2};
         r_sync  <= (&r_shift[SYNC_LEN-1:1]) & ~r_shift[0];
      end
   end

   assign o_sync  = r_sync;
   assign o_level = r_shift[SYNC_LEN-1];

endmodule

// File: rtl/phi_tracker.sv
// rtl/phi_tracker.sv - PHI2 clock recovery NCO with phase-strobe generation
// Ports: clk, reset_n (async active-low); phi2_in asynchronous host PHI2;
// phase_shift strobe advance in clk cycles (quasi-static);
// phi2_out regenerated PHI2; locked NCO lock; lost no qualified edge for
// 2^CNT_W-1 cycles; period integer divider (output period = period+1);
// full_m2..full_p1 / half_m2..half_p1 strobes around the falling / rising edge.
module phi_tracker
   import phi_pkg::*;
#(
   parameter int CNT_W      = PHI_CNT_W,
   parameter int GUARD_BITS = PHI_GUARD_BITS,
   parameter int SYNC_LEN   = PHI_SYNC_LEN,
   parameter int LOCK_BITS  = PHI_LOCK_BITS,
   parameter int TOL_BITS   = PHI_TOL_BITS
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             phi2_in,
   input  logic [CNT_W-1:0] phase_shift,
   output logic             phi2_out,
   output logic             locked,
   output logic             lost,
   output logic [CNT_W-1:0] period,
   output logic             full_m2,
   output logic             full_m1,
   output logic             full_p0,
   output logic             full_p1,
   output logic             half_m2,
   output logic             half_m1,
   output logic             half_p0,
   output logic             half_p1
);

   localparam int ACC_W = CNT_W + GUARD_BITS;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_PRE_MAX = ~CNT_W'(1);

   logic                  w_sync;
   logic                  w_level_unused;
   logic [CNT_W-1:0]      r_in_cnt;
   logic [CNT_W-1:0]      r_out_cnt;
   logic [CNT_W-1:0]      r_divider;
   logic [GUARD_BITS-1:0] r_frac;
   logic [GUARD_BITS-1:0] r_frac_cnt;
   logic                  r_lost;
   logic [LOCK_BITS-1:0]  r_lock_cnt;
   logic [3:0]            r_full;
   logic [3:0]            r_half;
   logic                  r_phi2;

   logic [CNT_W:0]          w_adjust;
   logic [CNT_W:TOL_BITS]   w_adj_hi;
   logic                    w_adj_in_tol;
   logic [ACC_W-1:0]        w_adj_ext;
   logic [ACC_W-1:0]        w_acc_next;
   logic [GUARD_BITS:0]     w_frac_sum;
   logic [CNT_W-1:0]        w_reload;
   logic [CNT_W-1:0]        w_out_ph;
   logic                    w_lost_set;
   logic                    w_full_hit;
   logic                    w_half_hit;

   phi_edge_sync #(
      .SYNC_LEN (SYNC_LEN)
   ) u_edge_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_phi2  (phi2_in),
      .o_sync  (w_sync),
      .o_level (w_level_unused)
   );

   // Phase error at each qualified edge; forced to zero in holdover so the
   // saturated input count cannot drag the divider.
   assign w_adjust     = (w_sync && !r_lost) ? ({1'b0, r_in_cnt} - {1'b0, r_divider}) : '0;
   assign w_adj_hi     = w_adjust[CNT_W:TOL_BITS];
   assign w_adj_in_tol = (w_adj_hi == '0) || (&w_adj_hi);
   assign w_adj_ext    = ACC_W'($signed(w_adjust));
   assign w_acc_next   = {r_divider, r_frac} + w_adj_ext;

   // Fractional accumulator: its carry decides whether the reload adds a cycle.
   assign w_frac_sum = {1'b0, r_frac_cnt} + {1'b0, ~r_frac};
   assign w_reload   = r_in_cnt + CNT_W'(w_frac_sum[GUARD_BITS]);

   assign w_lost_set = !w_sync && (r_in_cnt == CNT_PRE_MAX);

   assign w_out_ph   = r_out_cnt + phase_shift;
   assign w_full_hit = (w_out_ph == r_divider);
   assign w_half_hit = (w_out_ph == (r_divider >> 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_in_cnt   <= '0;
         r_lost     <= 1'b0;
         r_divider  <= '0;
         r_frac     <= '0;
         r_frac_cnt <= '0;
         r_out_cnt  <= '0;
         r_lock_cnt <= '0;
         r_full     <= '0;
         r_half     <= '0;
         r_phi2     <= 1'b0;
      end else begin
         if (w_sync) begin
            r_in_cnt <= '0;
         end else if (r_in_cnt != CNT_MAX) begin
            r_in_cnt <= r_in_cnt + CNT_ONE;
         end

         if (w_sync) begin
            r_lost <= 1'b0;
         end else if (w_lost_set) begin
            r_lost <= 1'b1;
         end

         {r_divider, r_frac} <= w_acc_next;

         // Re-phase the output counter to the input counter once per period;
         // in holdover it free-runs at the held divider.
         if (r_full[STB_M1] && !r_lost) begin
            r_frac_cnt <= w_frac_sum[GUARD_BITS-1:0];
            r_out_cnt  <= w_reload;
         end else if (r_out_cnt >= r_divider) begin
            r_out_cnt <= '0;
         end else begin
            r_out_cnt <= r_out_cnt + CNT_ONE;
         end

         r_full <= {r_full[STB_P0:STB_M2], w_full_hit};
         r_half <= {r_half[STB_P0:STB_M2], w_half_hit};

         // Clear has priority over set when both strobes coincide.
         if (r_full[STB_M1]) begin
            r_phi2 <= 1'b0;
         end else if (r_half[STB_M1]) begin
            r_phi2 <= 1'b1;
         end

         if (!w_adj_in_tol || w_lost_set) begin
            r_lock_cnt <= '0;
         end else if (w_sync && !r_lock_cnt[LOCK_BITS-1]) begin
            r_lock_cnt <= r_lock_cnt + LOCK_BITS'(1);
         end
      end
   end

   assign phi2_out = r_phi2;
   assign locked   = r_lock_cnt[LOCK_BITS-1];
   assign lost     = r_lost;
   assign period   = r_divider;
   assign full_m2  = r_full[STB_M2];
   assign full_m1  = r_full[STB_M1];
   assign full_p0  = r_full[STB_P0];
   assign full_p1  = r_full[STB_P1];
   assign half_m2  = r_half[STB_M2];
   assign half_m1  = r_half[STB_M1];
   assign half_p0  = r_half[STB_P0];
   assign half_p1  = r_half[STB_P1];

endmodule
